// File: rtl/sm3_expnd_core.sv
// SM3 message expansion: packs padded words into 512-bit blocks and streams (W_j, W'_j), j=0..63.
// Optional sticky protocol-error flag enabled by defining SM3_EXPND_ERR_EN.
module sm3_expnd_core #(
  parameter int unsigned INPT_DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INPT_DW-1:0] pad_d_i,
  input  logic               pad_vld_i,
  input  logic               pad_lst_i,
  output logic               pad_ena_o,
  output logic [31:0]        expnd_wj_o,
  output logic [31:0]        expnd_wjj_o,
  output logic [5:0]         expnd_idx_o,
  output logic               expnd_vld_o,
  input  logic               expnd_rdy_i,
  output logic               expnd_lst_o,
  output logic               expnd_err_o
);

  localparam int unsigned WPC = INPT_DW / 32;
  localparam int unsigned NW  = 16;
  localparam int unsigned CW  = 5;
  localparam int unsigned IW  = 6;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_EXPND = 1'b1;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    rotl = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    p1 = x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  logic [0:0]    state_q, state_d;
  logic [31:0]   buf_q [NW];
  logic [CW-1:0] cnt_q;
  logic          blk_lst_q;
  logic [31:0]   win_q [NW];
  logic [IW-1:0] j_q;
  logic          win_lst_q;
  logic [31:0]   wjj_q;
  logic          lst_q;

  logic          full_c;
  logic          acc_c;
  logic          last_c;
  logic          xfer_c;
  logic          take_c;
  logic [3:0]    base_c;
  logic [31:0]   win_new_c;

  assign full_c    = (cnt_q == CW'(NW));
  assign acc_c     = (state_q == S_EXPND) && expnd_rdy_i;
  assign last_c    = acc_c && (j_q == IW'(63));
  // A beat is taken when there is room, or when the full buffer empties into the window on this edge.
  assign take_c    = pad_vld_i && (!full_c || xfer_c);
  assign base_c    = xfer_c ? 4'd0 : cnt_q[3:0];
  assign win_new_c = p1(win_q[0] ^ win_q[7] ^ rotl(win_q[13], 15)) ^ rotl(win_q[3], 7) ^ win_q[10];

  // Drop enable one beat early so the upstream in-flight beat still fits.
  assign pad_ena_o = !full_c && !((cnt_q == CW'(NW - WPC)) && pad_vld_i);

  // Next-state: IDLE waits for a full buffer; EXPND reloads at j=63 only if the next block is ready.
  always_comb begin
    state_d = state_q;
    xfer_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_c) begin
          xfer_c  = 1'b1;
          state_d = S_EXPND;
        end
      end
      S_EXPND: begin
        if (last_c) begin
          if (full_c) xfer_c  = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Load buffer payload; earlier word of a 64-bit beat lands at the lower slot.
  always_ff @(posedge clk) begin
    if (take_c) begin
      buf_q[base_c] <= pad_d_i[INPT_DW-1 -: 32];
      if (WPC == 2) buf_q[base_c + 4'd1] <= pad_d_i[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      blk_lst_q <= 1'b0;
    end else if (xfer_c) begin
      cnt_q     <= pad_vld_i ? CW'(WPC) : '0;
      blk_lst_q <= pad_vld_i && pad_lst_i;
    end else if (take_c) begin
      cnt_q     <= cnt_q + CW'(WPC);
      blk_lst_q <= pad_lst_i;
    end
  end

  // Expansion window: win_q[k] holds W_{j+k}; W'_j and the last flag are precomputed one edge ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) win_q[k] <= '0;
      j_q       <= '0;
      win_lst_q <= 1'b0;
      wjj_q     <= '0;
      lst_q     <= 1'b0;
    end else if (xfer_c) begin
      for (int k = 0; k < NW; k++) win_q[k] <= buf_q[k];
      j_q       <= '0;
      win_lst_q <= blk_lst_q;
      wjj_q     <= buf_q[0] ^ buf_q[4];
      lst_q     <= 1'b0;
    end else if (acc_c) begin
      for (int k = 0; k < NW - 1; k++) win_q[k] <= win_q[k+1];
      win_q[NW-1] <= win_new_c;
      j_q         <= j_q + IW'(1);
      wjj_q       <= win_q[1] ^ win_q[5];
      lst_q       <= (j_q == IW'(62)) && win_lst_q;
    end
  end

  assign expnd_wj_o  = win_q[0];
  assign expnd_wjj_o = wjj_q;
  assign expnd_idx_o = j_q;
  assign expnd_vld_o = (state_q == S_EXPND);
  assign expnd_lst_o = lst_q;

`ifdef SM3_EXPND_ERR_EN
  logic          err_q;
  logic          drop_c;
  logic          bad_lst_c;
  logic [CW-1:0] cnt_nxt_c;

  assign cnt_nxt_c = xfer_c ? CW'(WPC) : cnt_q + CW'(WPC);
  assign drop_c    = pad_vld_i && full_c && !xfer_c;
  assign bad_lst_c = take_c && pad_lst_i && (cnt_nxt_c != CW'(NW));

  always_ff @(posedge clk) begin
    if (rst)                       err_q <= 1'b0;
    else if (drop_c || bad_lst_c)  err_q <= 1'b1;
  end

  assign expnd_err_o = err_q;
`else
  assign expnd_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sm3_expnd_core.sv
// Directed bench for sm3_expnd_core: 32-bit and 64-bit instances checked against a reference SM3 expansion.
module tb_sm3_expnd_core;

`ifdef SM3_EXPND_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] d32;
  logic        vld32, lst32, ena32, rdy32, ovld32, olst32, err32;
  logic [31:0] wj32, wjj32;
  logic [5:0]  idx32;
  logic [63:0] d64;
  logic        vld64, lst64, ena64, rdy64, ovld64, olst64, err64;
  logic [31:0] wj64, wjj64;
  logic [5:0]  idx64;

  sm3_expnd_core #(.INPT_DW(32)) u_dut32 (
    .clk(clk), .rst(rst), .pad_d_i(d32), .pad_vld_i(vld32), .pad_lst_i(lst32), .pad_ena_o(ena32),
    .expnd_wj_o(wj32), .expnd_wjj_o(wjj32), .expnd_idx_o(idx32), .expnd_vld_o(ovld32),
    .expnd_rdy_i(rdy32), .expnd_lst_o(olst32), .expnd_err_o(err32));

  sm3_expnd_core #(.INPT_DW(64)) u_dut64 (
    .clk(clk), .rst(rst), .pad_d_i(d64), .pad_vld_i(vld64), .pad_lst_i(lst64), .pad_ena_o(ena64),
    .expnd_wj_o(wj64), .expnd_wjj_o(wjj64), .expnd_idx_o(idx64), .expnd_vld_o(ovld64),
    .expnd_rdy_i(rdy64), .expnd_lst_o(olst64), .expnd_err_o(err64));

  int checks = 0;
  int failures = 0;
  logic [31:0] msg [2][16];
  logic [31:0] wref [2][68];

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook recurrence over the whole W array.
  task automatic build_refs();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) wref[s][i] = msg[s][i];
      for (int j = 16; j < 68; j++) begin
        logic [31:0] t;
        t = wref[s][j-16] ^ wref[s][j-9] ^ rl(wref[s][j-3], 15);
        wref[s][j] = (t ^ rl(t, 15) ^ rl(t, 23)) ^ rl(wref[s][j-13], 7) ^ wref[s][j-6];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load32(input int sel, input logic lst);
    for (int i = 0; i < 16; i++) begin
      vld32 = 1'b1; d32 = msg[sel][i]; lst32 = lst && (i == 15);
      tick();
    end
    vld32 = 1'b0; lst32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if ({ovld32, olst32, err32, wj32, wjj32, idx32} !== '0) begin failures++; $display("FAIL reset_out32 got=%h exp=0", {ovld32, olst32, err32, wj32, wjj32, idx32}); end
    checks++; if (ena32 !== 1'b1) begin failures++; $display("FAIL reset_ena32 got=%b exp=1", ena32); end
    checks++; if ({ovld64, olst64, err64, wj64, wjj64, idx64} !== '0) begin failures++; $display("FAIL reset_out64 got=%h exp=0", {ovld64, olst64, err64, wj64, wjj64, idx64}); end
    checks++; if (ena64 !== 1'b1) begin failures++; $display("FAIL reset_ena64 got=%b exp=1", ena64); end
    rst = 1'b0;
  endtask

  task automatic test_abc32();
    for (int i = 0; i < 16; i++) begin
      vld32 = 1'b1; d32 = msg[0][i]; lst32 = (i == 15);
      #1;
      checks++; if (ena32 !== (i != 15)) begin failures++; $display("FAIL abc32_ena beat=%0d got=%b exp=%b", i, ena32, (i != 15)); end
      tick();
    end
    vld32 = 1'b0; lst32 = 1'b0;
    #1;
    checks++; if ({ena32, ovld32} !== 2'b00) begin failures++; $display("FAIL abc32_full got=%b%b exp=00", ena32, ovld32); end
    tick();
    for (int j = 0; j < 64; j++) begin
      checks++; if ({ovld32, idx32, olst32} !== {1'b1, 6'(j), j == 63}) begin failures++; $display("FAIL abc32_ctl j=%0d got vld=%b idx=%0d lst=%b", j, ovld32, idx32, olst32); end
      checks++; if ({wj32, wjj32} !== {wref[0][j], wref[0][j] ^ wref[0][j+4]}) begin failures++; $display("FAIL abc32_data j=%0d got=%h/%h exp=%h/%h", j, wj32, wjj32, wref[0][j], wref[0][j] ^ wref[0][j+4]); end
      if (j == 0) begin
        checks++; if ({wj32, wjj32} !== {32'h61626380, 32'h61626380}) begin failures++; $display("FAIL abc32_w0 got=%h/%h exp=61626380/61626380", wj32, wjj32); end
      end
      if (j == 15) begin
        checks++; if (wj32 !== 32'h00000018) begin failures++; $display("FAIL abc32_w15 got=%h exp=00000018", wj32); end
      end
      if (j == 16) begin
        checks++; if (wj32 !== 32'h9092e200) begin failures++; $display("FAIL abc32_w16 got=%h exp=9092e200", wj32); end
      end
      tick();
    end
    checks++; if (ovld32 !== 1'b0) begin failures++; $display("FAIL abc32_end_vld got=%b exp=0", ovld32); end
  endtask

  task automatic test_abc64();
    for (int i = 0; i < 8; i++) begin
      vld64 = 1'b1; d64 = {msg[0][2*i], msg[0][2*i+1]}; lst64 = (i == 7);
      #1;
      checks++; if (ena64 !== (i != 7)) begin failures++; $display("FAIL abc64_ena beat=%0d got=%b exp=%b", i, ena64, (i != 7)); end
      tick();
    end
    vld64 = 1'b0; lst64 = 1'b0;
    #1;
    checks++; if (ena64 !== 1'b0) begin failures++; $display("FAIL abc64_ena_after got=%b exp=0", ena64); end
    tick();
    for (int j = 0; j < 64; j++) begin
      checks++; if ({ovld64, idx64, olst64} !== {1'b1, 6'(j), j == 63}) begin failures++; $display("FAIL abc64_ctl j=%0d got vld=%b idx=%0d lst=%b", j, ovld64, idx64, olst64); end
      checks++; if ({wj64, wjj64} !== {wref[0][j], wref[0][j] ^ wref[0][j+4]}) begin failures++; $display("FAIL abc64_data j=%0d got=%h/%h exp=%h/%h", j, wj64, wjj64, wref[0][j], wref[0][j] ^ wref[0][j+4]); end
      tick();
    end
    checks++; if (ovld64 !== 1'b0) begin failures++; $display("FAIL abc64_end_vld got=%b exp=0", ovld64); end
  endtask

  task automatic test_back_to_back();
    load32(0, 1'b0);
    tick();
    for (int j = 0; j < 64; j++) begin
      vld32 = (j < 16); d32 = msg[1][j % 16]; lst32 = (j == 15);
      checks++; if ({ovld32, idx32, olst32} !== {1'b1, 6'(j), 1'b0}) begin failures++; $display("FAIL b2b_a_ctl j=%0d got vld=%b idx=%0d lst=%b", j, ovld32, idx32, olst32); end
      checks++; if ({wj32, wjj32} !== {wref[0][j], wref[0][j] ^ wref[0][j+4]}) begin failures++; $display("FAIL b2b_a_data j=%0d got=%h/%h", j, wj32, wjj32); end
      tick();
    end
    vld32 = 1'b0; lst32 = 1'b0;
    for (int j = 0; j < 64; j++) begin
      checks++; if ({ovld32, idx32, olst32} !== {1'b1, 6'(j), j == 63}) begin failures++; $display("FAIL b2b_b_ctl j=%0d got vld=%b idx=%0d lst=%b", j, ovld32, idx32, olst32); end
      checks++; if ({wj32, wjj32} !== {wref[1][j], wref[1][j] ^ wref[1][j+4]}) begin failures++; $display("FAIL b2b_b_data j=%0d got=%h/%h exp=%h/%h", j, wj32, wjj32, wref[1][j], wref[1][j] ^ wref[1][j+4]); end
      tick();
    end
    checks++; if (ovld32 !== 1'b0) begin failures++; $display("FAIL b2b_end_vld got=%b exp=0", ovld32); end
  endtask

  task automatic test_stall();
    load32(0, 1'b1);
    tick();
    for (int j = 0; j < 64; j++) begin
      checks++; if ({ovld32, idx32, olst32} !== {1'b1, 6'(j), j == 63}) begin failures++; $display("FAIL stall_ctl j=%0d got vld=%b idx=%0d lst=%b", j, ovld32, idx32, olst32); end
      checks++; if ({wj32, wjj32} !== {wref[0][j], wref[0][j] ^ wref[0][j+4]}) begin failures++; $display("FAIL stall_data j=%0d got=%h/%h", j, wj32, wjj32); end
      if (j == 20) begin
        rdy32 = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++; if ({ovld32, idx32, olst32, wj32, wjj32} !== {1'b1, 6'd20, 1'b0, wref[0][20], wref[0][20] ^ wref[0][24]}) begin failures++; $display("FAIL stall_hold cyc=%0d got idx=%0d wj=%h wjj=%h", s, idx32, wj32, wjj32); end
        end
        rdy32 = 1'b1;
      end
      tick();
    end
    checks++; if (ovld32 !== 1'b0) begin failures++; $display("FAIL stall_end_vld got=%b exp=0", ovld32); end
  endtask

  task automatic test_rst_mid();
    bit done;
    load32(0, 1'b0);
    tick();
    for (int j = 0; j < 30; j++) begin
      vld32 = (j < 8); d32 = msg[1][j % 16];
      tick();
    end
    vld32 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({ovld32, olst32, err32, wj32, wjj32, idx32} !== '0) begin failures++; $display("FAIL rstmid_out got=%h exp=0", {ovld32, olst32, err32, wj32, wjj32, idx32}); end
    checks++; if (ena32 !== 1'b1) begin failures++; $display("FAIL rstmid_ena got=%b exp=1", ena32); end
    for (int i = 0; i < 16; i++) begin
      vld32 = 1'b1; d32 = msg[0][i]; lst32 = 1'b0;
      checks++; if (ovld32 !== 1'b0) begin failures++; $display("FAIL rstmid_early_vld beat=%0d got=%b exp=0", i, ovld32); end
      tick();
    end
    vld32 = 1'b0;
    tick();
    checks++; if ({ovld32, idx32, wj32} !== {1'b1, 6'd0, 32'h61626380}) begin failures++; $display("FAIL rstmid_w0 got vld=%b idx=%0d wj=%h exp 1/0/61626380", ovld32, idx32, wj32); end
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      done = (ovld32 === 1'b0);
    end
    checks++; if (!done) begin failures++; $display("FAIL rstmid_drain timeout vld=%b", ovld32); end
  endtask

  task automatic test_err();
    bit done;
    rst = 1'b1; tick(); rst = 1'b0;
    load32(0, 1'b0);
    tick();
    rdy32 = 1'b0;
    load32(1, 1'b0);
    checks++; if ({err32, ena32} !== 2'b00) begin failures++; $display("FAIL err_before got err=%b ena=%b exp 0/0", err32, ena32); end
    vld32 = 1'b1; d32 = 32'hdeadbeef;
    tick();
    vld32 = 1'b0;
    checks++; if (err32 !== ERR_EN) begin failures++; $display("FAIL err_drop got=%b exp=%b", err32, ERR_EN); end
    rdy32 = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      done = (ovld32 === 1'b0);
    end
    checks++; if (!done) begin failures++; $display("FAIL err_drain timeout vld=%b", ovld32); end
    checks++; if (err32 !== ERR_EN) begin failures++; $display("FAIL err_sticky got=%b exp=%b", err32, ERR_EN); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (err32 !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err32); end
    for (int i = 0; i < 5; i++) begin
      vld32 = 1'b1; d32 = msg[1][i]; lst32 = (i == 4);
      tick();
    end
    vld32 = 1'b0; lst32 = 1'b0;
    checks++; if (err32 !== ERR_EN) begin failures++; $display("FAIL err_early_lst got=%b exp=%b", err32, ERR_EN); end
    tick();
    checks++; if ({err32, ovld32} !== {ERR_EN, 1'b0}) begin failures++; $display("FAIL err_early_lst_hold got err=%b vld=%b", err32, ovld32); end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d32 = '0; vld32 = 1'b0; lst32 = 1'b0; rdy32 = 1'b1;
    d64 = '0; vld64 = 1'b0; lst64 = 1'b0; rdy64 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      msg[0][i] = (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
      msg[1][i] = 32'(32'h9e3779b9 * (i + 1)) ^ 32'h00ff00ff;
    end
    build_refs();
    test_reset();
    test_abc32();
    test_abc64();
    test_back_to_back();
    test_stall();
    test_rst_mid();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm3_expnd_core.md
Name: sm3_expnd_core

Overview:
- Downstream neighbour of the SM3 padding stage.
- Collects the padded word stream into 512-bit blocks in a 16-word load buffer.
- Runs the SM3 message expansion and presents one (W_j, W'_j) pair per cycle, j=0..63, to the compression stage.
- Load buffer and expansion window are separate, so the next block loads while the current one expands. Back-to-back blocks have no bubble.

Parameters:
- INPT_DW, 32, input data width; 32 or 64 only. WPC = INPT_DW/32 words per input beat.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pad_d_i  in  INPT_DW  padded data; for 64-bit, bits [63:32] are the earlier word
- pad_vld_i  in  1  pad_d_i valid
- pad_lst_i  in  1  final beat of final block of the message
- pad_ena_o  out  1  load buffer can take data; drives the padding stage's enable input
- expnd_wj_o  out  32  W_j
- expnd_wjj_o  out  32  W'_j = W_j ^ W_{j+4}
- expnd_idx_o  out  6  round index j
- expnd_vld_o  out  1  output pair valid
- expnd_rdy_i  in  1  compression stage accepts the pair
- expnd_lst_o  out  1  with j=63 of the message's final block
- expnd_err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: synchronous, one rising edge with rst=1. Values after reset:
  - all outputs 0, except pad_ena_o=1;
  - load count 0, window empty, error cleared.
  - Reset mid-block discards all partial state. No output until a fresh 16 words are loaded.
- Load buffer:
  - 16x32 registers plus a 5-bit count (0..16) and a blk_lst flag.
  - On pad_vld_i with count<16: write WPC words at count, in big-endian word order, then count += WPC.
  - When pad_lst_i arrives with an accepted beat, capture it into blk_lst.
  - pad_ena_o = (count<16) and not (count==16-WPC and pad_vld_i). This is combinational and absorbs the one-cycle in-flight beat of the upstream stage.
  - Beat with count==16 and no transfer on the same edge: dropped, and the error condition raised.
- State machine, 2 states:
  - IDLE: expnd_vld_o=0. When count==16, transfer the buffer into the window on the next edge. Then count=0, j=0, window lst=blk_lst, go to EXPND.
  - EXPND: expnd_vld_o=1. The pair advances only on the edge where vld&&rdy.
    - On the accepting edge at j=63 with count==16: transfer immediately and stay in EXPND. This is the zero-bubble path.
    - On the accepting edge at j=63 otherwise: go to IDLE.
  - Simultaneous load of the final beat and the j=63 accept: the transfer happens on the following edge. A new beat is never written into a slot being transferred.
- Latency: the first pair is visible 2 cycles after the beat completing the block is presented, provided the window is free.
- Window: 16x32 registers win[0..15]; win[k] = W_{j+k}.
  - Outputs: expnd_wj_o=win[0]; expnd_wjj_o=win[0]^win[4]; expnd_idx_o=j.
  - On accept: win[k]<=win[k+1], and win[15] <= P1(win[0]^win[7]^rotl(win[13],15)) ^ rotl(win[3],7) ^ win[10].
  - P1(x) = x ^ rotl(x,15) ^ rotl(x,23). Calculations are 32-bit modulo with no carries.
  - Words generated beyond j=63 are never presented.
- Stall: while expnd_rdy_i=0, all expnd_* outputs hold stable. Loading continues independently.
- expnd_lst_o = expnd_vld_o && j==63 && window lst.

Optional Feature:
- Macro SM3_EXPND_ERR_EN.
- Defined: expnd_err_o is set sticky (cleared only by rst) on either event:
  - a beat dropped because the buffer is full;
  - pad_lst_i on a beat that does not complete a block (count after write != 16).
  - Data flow is unaffected.
- Undefined: expnd_err_o is tied 0. The check logic is absent and dropped beats are silently discarded.

Test Plan:
- "abc" block, INPT_DW=32, 16 beats, expnd_rdy_i=1:
  - W0 = 0x61626380, W'0 = 0x61626380, W15 = 0x00000018, W16 = 0x9092e200;
  - expnd_lst_o only at j=63;
  - 64 valid cycles, then expnd_vld_o=0.
- Same block with INPT_DW=64, 8 beats: pairs identical to the 32-bit case; pad_ena_o drops after beat 8.
- Two blocks back-to-back, second fully loaded before j=63 of the first:
  - j=0 of block 2 on the cycle after j=63 of block 1;
  - expnd_lst_o only on block 2's j=63 when lst is on block 2.
- Toggle expnd_rdy_i (stall 3 cycles at j=20):
  - outputs frozen for 3 cycles;
  - the sequence is identical to the no-stall run.
- rst asserted at j=30 with the buffer half full:
  - next cycle all outputs are 0 and pad_ena_o=1;
  - a fresh block produces the correct W0.
- With SM3_EXPND_ERR_EN defined:
  - a 17th beat while blocked sets expnd_err_o=1, which holds until rst;
  - pad_lst_i on beat 5 sets expnd_err_o.
- With SM3_EXPND_ERR_EN undefined: both cases above leave expnd_err_o=0.
